// File: rtl/ma_multacc_pkg.sv
// Shared constants and width helpers for the multi-channel multiply-accumulate engine.
package ma_multacc_pkg;

  localparam logic MA_OP_ADD = 1'b0;
  localparam logic MA_OP_SUB = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Channel tag width; a single-channel build still carries a 1-bit tag.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ma_mult_stage.sv
// First pipeline stage: operand extension, shared multiplier, registered product and sideband.
module ma_mult_stage
  import ma_multacc_pkg::*;
#(
  parameter int ASIZE    = 18,
  parameter int BSIZE    = 18,
  parameter int PSIZE    = 48,
  parameter int N_CH     = 4,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1,
  localparam int CHW     = ch_width(N_CH),
  localparam int MW      = ASIZE + BSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [CHW-1:0]   in_ch,
  input  logic [ASIZE-1:0] a,
  input  logic [BSIZE-1:0] b,
  input  logic             in_sub,
  input  logic             reload,
  input  logic [PSIZE-1:0] acc_init,
  input  logic             in_last,
  output logic             v1,
  output logic [MW-1:0]    prod_r,
  output logic [CHW-1:0]   ch_r,
  output logic             sub_r,
  output logic             reload_r,
  output logic [PSIZE-1:0] init_r,
  output logic             last_r
);

  localparam logic [CHW:0] NCH_L = (CHW+1)'(N_CH);

  logic [MW-1:0] a_x;
  logic [MW-1:0] b_x;
  logic [MW-1:0] prod;
  logic          accept;

  // The exact product always fits MW bits, so extending both operands to MW and
  // keeping the low MW bits of the multiply gives the correct result for any signedness.
  if (A_SIGNED != 0) begin : g_a_s
    assign a_x = {{BSIZE{a[ASIZE-1]}}, a};
  end else begin : g_a_u
    assign a_x = {{BSIZE{1'b0}}, a};
  end

  if (B_SIGNED != 0) begin : g_b_s
    assign b_x = {{ASIZE{b[BSIZE-1]}}, b};
  end else begin : g_b_u
    assign b_x = {{ASIZE{1'b0}}, b};
  end

  assign prod   = a_x * b_x;
  assign accept = ce & in_valid & ({1'b0, in_ch} < NCH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      prod_r   <= '0;
      ch_r     <= '0;
      sub_r    <= 1'b0;
      reload_r <= 1'b0;
      init_r   <= '0;
      last_r   <= 1'b0;
    end else if (ce) begin
      v1 <= accept;
      if (accept) begin
        prod_r   <= prod;
        ch_r     <= in_ch;
        sub_r    <= in_sub;
        reload_r <= reload;
        init_r   <= acc_init;
        last_r   <= in_last;
      end
    end
  end

endmodule

// File: rtl/ma_multich_acc.sv
// Multi-channel pipelined MAC: shared multiplier, per-channel accumulators, framed results.
// Optional MA_SATURATE_EN: signed saturation of the accumulator with an out_sat flag.
module ma_multich_acc
  import ma_multacc_pkg::*;
#(
  parameter int ASIZE    = 18,
  parameter int BSIZE    = 18,
  parameter int PSIZE    = 48,
  parameter int N_CH     = 4,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1,
  localparam int CHW     = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [CHW-1:0]   in_ch,
  input  logic [ASIZE-1:0] a,
  input  logic [BSIZE-1:0] b,
  input  logic             in_sub,
  input  logic             reload,
  input  logic [PSIZE-1:0] acc_init,
  input  logic             in_last,
  output logic             out_valid,
  output logic [CHW-1:0]   out_ch,
  output logic [PSIZE-1:0] p,
  output logic             out_sat
);

  localparam int MW = ASIZE + BSIZE;

  logic             v1;
  logic [MW-1:0]    prod_r;
  logic [CHW-1:0]   ch_r;
  logic             sub_r;
  logic             reload_r;
  logic [PSIZE-1:0] init_r;
  logic             last_r;

  logic [PSIZE-1:0] acc [N_CH];
  logic [PSIZE-1:0] prod_x;
  logic [PSIZE-1:0] base;
  logic [PSIZE-1:0] sum;
  logic [PSIZE-1:0] nxt;

  ma_mult_stage #(
    .ASIZE    (ASIZE),
    .BSIZE    (BSIZE),
    .PSIZE    (PSIZE),
    .N_CH     (N_CH),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .a        (a),
    .b        (b),
    .in_sub   (in_sub),
    .reload   (reload),
    .acc_init (acc_init),
    .in_last  (in_last),
    .v1       (v1),
    .prod_r   (prod_r),
    .ch_r     (ch_r),
    .sub_r    (sub_r),
    .reload_r (reload_r),
    .init_r   (init_r),
    .last_r   (last_r)
  );

  if (PSIZE == MW) begin : g_px_eq
    assign prod_x = prod_r;
  end else if (A_SIGNED != 0 || B_SIGNED != 0) begin : g_px_s
    assign prod_x = {{(PSIZE-MW){prod_r[MW-1]}}, prod_r};
  end else begin : g_px_u
    assign prod_x = {{(PSIZE-MW){1'b0}}, prod_r};
  end

  // Accumulator is read and written by the same stage, so back-to-back samples on one channel chain directly.
  assign base = reload_r ? init_r : acc[ch_r];
  assign sum  = (sub_r == MA_OP_SUB) ? (base - prod_x) : (base + prod_x);

`ifdef MA_SATURATE_EN
  localparam logic [PSIZE-1:0] P_MAX = {1'b0, {(PSIZE-1){1'b1}}};
  localparam logic [PSIZE-1:0] P_MIN = {1'b1, {(PSIZE-1){1'b0}}};

  logic ovf;
  logic sat_q;

  // Overflow only when the effective operands agree in sign and the result sign flips.
  always_comb begin
    ovf = 1'b0;
    nxt = sum;
    if (sum[PSIZE-1] != base[PSIZE-1]) begin
      ovf = (sub_r == MA_OP_SUB) ? (base[PSIZE-1] != prod_x[PSIZE-1])
                                 : (base[PSIZE-1] == prod_x[PSIZE-1]);
    end
    if (ovf) nxt = base[PSIZE-1] ? P_MIN : P_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= ce & v1 & last_r & ovf;
  end

  assign out_sat = sat_q;
`else
  assign nxt     = sum;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      p         <= '0;
    end else begin
      out_valid <= ce & v1 & last_r;
      if (ce & v1) begin
        acc[ch_r] <= nxt;
        if (last_r) begin
          p      <= nxt;
          out_ch <= ch_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_multich_acc.sv
// Bench for ma_multich_acc: directed vector table, hand sequences for ce/reset, randomized run against an arithmetic model.
module tb_ma_multich_acc;
  import ma_multacc_pkg::*;

  localparam int ASIZE = 18;
  localparam int BSIZE = 18;
  localparam int PSIZE = 36;
  localparam int N_CH  = 3;
  localparam int CHW   = ch_width(N_CH);

  localparam longint HALF = longint'(1) << (PSIZE - 1);
  localparam longint MASK = (longint'(1) << PSIZE) - 1;
  localparam longint PMAX = HALF - 1;
  localparam longint PMIN = -HALF;

  logic             clk = 1'b0;
  logic             rst, ce, in_valid, in_sub, reload, in_last;
  logic [CHW-1:0]   in_ch;
  logic [ASIZE-1:0] a;
  logic [BSIZE-1:0] b;
  logic [PSIZE-1:0] acc_init;
  logic             out_valid, out_sat;
  logic [CHW-1:0]   out_ch;
  logic [PSIZE-1:0] p;

  ma_multich_acc #(
    .ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE), .N_CH(N_CH), .A_SIGNED(1), .B_SIGNED(1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ch(in_ch), .a(a), .b(b),
    .in_sub(in_sub), .reload(reload), .acc_init(acc_init), .in_last(in_last),
    .out_valid(out_valid), .out_ch(out_ch), .p(p), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     vld;
    int     ch;
    int     a;
    int     b;
    bit     sub;
    bit     rl;
    longint init;
    bit     last;
    bit     ce;
    longint exp_p;
    bit     exp_sat;
  } vec_t;

  typedef struct {
    logic [PSIZE-1:0] p;
    int               ch;
    bit               sat;
    int               due;
  } exp_t;

  exp_t   expq[$];
  vec_t   tbl[$];
  longint macc[N_CH];
  int     n_chk  = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint sext(input longint v);
    return ((v & MASK) ^ HALF) - HALF;
  endfunction

  function automatic vec_t mk(input bit vld, input int ch, input int av, input int bv,
                              input bit sub, input bit rl, input longint init, input bit last,
                              input longint exp_p, input bit exp_sat);
    vec_t s;
    s.vld = vld; s.ch = ch; s.a = av; s.b = bv; s.sub = sub; s.rl = rl; s.init = init;
    s.last = last; s.ce = 1'b1; s.exp_p = exp_p; s.exp_sat = exp_sat;
    return s;
  endfunction

  // Behavioural model: signed integers, result either clamped or reduced modulo 2^PSIZE.
  task automatic model_step(input vec_t s, output logic [PSIZE-1:0] ep, output bit es);
    longint base, prod, nxt;
    base = s.rl ? sext(s.init) : macc[s.ch];
    prod = longint'(s.a) * longint'(s.b);
    nxt  = s.sub ? base - prod : base + prod;
    es   = 1'b0;
`ifdef MA_SATURATE_EN
    if (nxt > PMAX) begin nxt = PMAX; es = 1'b1; end
    else if (nxt < PMIN) begin nxt = PMIN; es = 1'b1; end
`else
    nxt = sext(nxt);
`endif
    macc[s.ch] = nxt;
    ep = PSIZE'(nxt & MASK);
  endtask

  // due_ofs < 0 disables the latency check for that result.
  task automatic apply(input vec_t s, input bit from_model, input int due_ofs);
    logic [PSIZE-1:0] ep;
    bit               es;
    exp_t             e;
    @(negedge clk);
    ce = s.ce; in_valid = s.vld; in_ch = CHW'(s.ch); a = ASIZE'(s.a); b = BSIZE'(s.b);
    in_sub = s.sub; reload = s.rl; acc_init = PSIZE'(s.init); in_last = s.last;
    if (s.ce && s.vld && s.ch < N_CH) begin
      model_step(s, ep, es);
      if (s.last) begin
        e.p   = from_model ? ep : PSIZE'(s.exp_p);
        e.sat = from_model ? es : s.exp_sat;
        e.ch  = s.ch;
        e.due = (due_ofs < 0) ? -1 : cyc + due_ofs;
        expq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input bit ce_v);
    vec_t s;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.ce = ce_v;
    for (int i = 0; i < n; i++) apply(s, 0, -1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        check("out_valid_unexpected", 64'(out_valid), 64'd0);
      end else begin
        e = expq.pop_front();
        check("p", 64'(p), 64'(e.p));
        check("out_ch", 64'(out_ch), 64'(e.ch));
        check("out_sat", 64'(out_sat), 64'(e.sat));
        if (e.due >= 0) check("latency_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_ch = '0; a = '0; b = '0;
    in_sub = 1'b0; reload = 1'b0; acc_init = '0; in_last = 1'b0;
    for (int i = 0; i < N_CH; i++) macc[i] = 0;

    // directed vectors: {vld, ch, a, b, sub, reload, init, last, expected p, expected sat}
    tbl.push_back(mk(1, 0,  3,  4, 0, 1, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0,  5,  6, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, -2,  7, 0, 0, 0, 1, 28, 0));
    tbl.push_back(mk(1, 1,  1,  1, 0, 1, 0, 0,  0, 0));
    tbl.push_back(mk(1, 2, 10, 10, 0, 1, 0, 0,  0, 0));
    tbl.push_back(mk(1, 1,  1,  1, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 2, 10, 10, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 1,  1,  1, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 2, 10, 10, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 1,  1,  1, 0, 0, 0, 1,  4, 0));
    tbl.push_back(mk(1, 2, 10, 10, 0, 0, 0, 1, 400, 0));
    tbl.push_back(mk(1, 0,  5,  5, 1, 1, 100, 1, 75, 0));
    tbl.push_back(mk(1, 3,  9,  9, 0, 0, 0, 1,  0, 0));
    tbl.push_back(mk(1, 0,  1,  1, 0, 0, 0, 1, 76, 0));
    tbl.push_back(mk(1, 2,  3, -4, 1, 1, -5, 1, 7, 0));
    tbl.push_back(mk(1, 1, -131072, -131072, 0, 1, 0, 0, 0, 0));
`ifdef MA_SATURATE_EN
    tbl.push_back(mk(1, 1, -131072, -131072, 0, 0, 0, 1, 64'h7_FFFF_FFFF, 1));
`else
    tbl.push_back(mk(1, 1, -131072, -131072, 0, 0, 0, 1, 64'h8_0000_0000, 0));
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_p", 64'(p), 64'd0);
    check("reset_out_ch", 64'(out_ch), 64'd0);
    check("reset_out_sat", 64'(out_sat), 64'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 0, 2);
    idle(4, 1'b1);
    check("table_drain", 64'(expq.size()), 64'd0);

    // ce held low for 3 clocks while a last sample sits in the accumulate stage
    apply(mk(1, 1, 2, 3, 0, 1, 7, 1, 13, 0), 0, 5);
    idle(3, 1'b0);
    idle(4, 1'b1);
    check("ce_drain", 64'(expq.size()), 64'd0);

    // reset mid-frame: in-flight samples are discarded and all accumulators clear
    apply(mk(1, 2, 3, 3, 0, 0, 0, 0, 0, 0), 0, 2);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_ch = CHW'(2); a = ASIZE'(1); b = BSIZE'(1);
    in_last = 1'b1; reload = 1'b0; in_sub = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    for (int i = 0; i < N_CH; i++) macc[i] = 0;
    expq.delete();
    apply(mk(1, 2, 2, 2, 0, 0, 0, 1, 4, 0), 0, 2);
    idle(4, 1'b1);
    check("rst_drain", 64'(expq.size()), 64'd0);

    // randomized traffic, including invalid channels and ce stalls
    for (int i = 0; i < 500; i++) begin
      s.ce      = ($urandom_range(0, 9) != 0);
      s.vld     = ($urandom_range(0, 3) != 0);
      s.ch      = int'($urandom_range(0, 3));
      s.a       = int'($urandom_range(0, 262143)) - 131072;
      s.b       = int'($urandom_range(0, 262143)) - 131072;
      s.sub     = $urandom_range(0, 1) != 0;
      s.rl      = ($urandom_range(0, 7) == 0);
      s.init    = sext(longint'({$urandom, $urandom}));
      s.last    = ($urandom_range(0, 3) == 0);
      s.exp_p   = 0;
      s.exp_sat = 1'b0;
      apply(s, 1, -1);
    end
    idle(5, 1'b1);
    check("random_drain", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
